// File: rtl/serializer_pkg.sv
// Shared definitions for the buffered serializer: length decode, default minimum
// length and the shift-core state encoding.
package serializer_pkg;

   localparam int MIN_LEN_DEFAULT = 3;

   typedef logic [0:0] state_t;
   localparam state_t ST_IDLE  = 1'b0;
   localparam state_t ST_SHIFT = 1'b1;

   // A zero length code selects the full word width.
   function automatic int unsigned len_decode(input int unsigned mod, input int unsigned data_w);
      return (mod == 0) ? data_w : mod;
   endfunction

endpackage

// File: rtl/ser_shift_core.sv
// Shift register, bit counter and IDLE/SHIFT FSM. Emits one bit per cycle and can
// reload on the cycle of its last bit so consecutive words leave no gap.
module ser_shift_core
   import serializer_pkg::*;
#(
   parameter int DATA_W = 16,
   parameter int LEN_W  = 5
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic              load_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [LEN_W-1:0]  len_i,
   input  logic              lsb_first_i,
   output logic              free_o,
   output logic              last_o,
   output logic              ser_data_o,
   output logic              ser_val_o
);

   state_t            state_q;
   logic [DATA_W-1:0] shift_q;
   logic [LEN_W-1:0]  cnt_q;
   logic              lsb_q;
   logic              load_ok;

   assign ser_val_o  = (state_q == ST_SHIFT);
   assign last_o     = ser_val_o && (cnt_q == '0);
   assign free_o     = !ser_val_o || last_o;
   assign load_ok    = load_i && free_o;
   assign ser_data_o = ser_val_o && (lsb_q ? shift_q[0] : shift_q[DATA_W-1]);

   // NOTE: sequential state uses non-blocking assignments only, so every flop here
   // samples the pre-edge value of every other flop regardless of statement order.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         state_q <= ST_IDLE;
         shift_q <= '0;
         cnt_q   <= '0;
         lsb_q   <= 1'b0;
      end else if (load_ok) begin
         state_q <= ST_SHIFT;
         shift_q <= data_i;
         cnt_q   <= len_i - LEN_W'(1);
         lsb_q   <= lsb_first_i;
      end else if (state_q == ST_SHIFT) begin
         if (cnt_q == '0) begin
            state_q <= ST_IDLE;
            shift_q <= '0;
         end else begin
            shift_q <= lsb_q ? (shift_q >> 1) : (shift_q << 1);
            cnt_q   <= cnt_q - LEN_W'(1);
         end
      end
   end

endmodule

// File: rtl/serializer_buffered.sv
// Buffered serializer top: drop filter for short words, one-word pending register
// and ready/busy generation around the shift core.
module serializer_buffered
   import serializer_pkg::*;
#(
   parameter int DATA_W  = 16,
   parameter int MOD_W   = $clog2(DATA_W),
   parameter int MIN_LEN = MIN_LEN_DEFAULT
) (
   input  logic              clk_i,
   input  logic              srst_i,
   input  logic [DATA_W-1:0] data_i,
   input  logic [MOD_W-1:0]  data_mod_i,
   input  logic              lsb_first_i,
   input  logic              data_val_i,
   output logic              ready_o,
   output logic              ser_data_o,
   output logic              ser_data_val_o,
   output logic              busy_o
);

   localparam int LEN_W = MOD_W + 1;

   logic [LEN_W-1:0]  len_in;
   logic              keep;
   logic              accept;
   logic              core_free;
   logic              core_last;
   logic              to_pend;

   logic              pend_valid_q;
   logic [DATA_W-1:0] pend_data_q;
   logic [LEN_W-1:0]  pend_len_q;
   logic              pend_lsb_q;
   logic              ready_q;

   logic              ld;
   logic [DATA_W-1:0] ld_data;
   logic [LEN_W-1:0]  ld_len;
   logic              ld_lsb;

   assign len_in  = LEN_W'(len_decode(32'(data_mod_i), 32'(DATA_W)));
   assign keep    = (len_in >= LEN_W'(MIN_LEN));
   assign accept  = data_val_i && ready_q;
   assign to_pend = accept && keep && !core_free;

   // NOTE: every always_comb output gets a default first so no path leaves it
   // unassigned, which would otherwise infer a latch.
   always_comb begin
      ld      = 1'b0;
      ld_data = pend_data_q;
      ld_len  = pend_len_q;
      ld_lsb  = pend_lsb_q;
      if (core_free) begin
         if (pend_valid_q) begin
            ld = 1'b1;
         end else if (accept && keep) begin
            ld      = 1'b1;
            ld_data = data_i;
            ld_len  = len_in;
            ld_lsb  = lsb_first_i;
         end
      end
   end

   // NOTE: the pending payload is cleared on reset along with its valid flag, so a
   // word aborted by reset never leaves stale data behind.
   always_ff @(posedge clk_i) begin
      if (srst_i) begin
         pend_valid_q <= 1'b0;
         pend_data_q  <= '0;
         pend_len_q   <= '0;
         pend_lsb_q   <= 1'b0;
         ready_q      <= 1'b1;
      end else if (to_pend) begin
         pend_valid_q <= 1'b1;
         pend_data_q  <= data_i;
         pend_len_q   <= len_in;
         pend_lsb_q   <= lsb_first_i;
         ready_q      <= 1'b0;
      end else if (core_free && pend_valid_q) begin
         pend_valid_q <= 1'b0;
         ready_q      <= 1'b1;
      end
   end

   ser_shift_core #(
      .DATA_W (DATA_W),
      .LEN_W  (LEN_W)
   ) u_core (
      .clk_i       (clk_i),
      .srst_i      (srst_i),
      .load_i      (ld),
      .data_i      (ld_data),
      .len_i       (ld_len),
      .lsb_first_i (ld_lsb),
      .free_o      (core_free),
      .last_o      (core_last),
      .ser_data_o  (ser_data_o),
      .ser_val_o   (ser_data_val_o)
   );

   assign ready_o = ready_q;
   assign busy_o  = ser_data_val_o || pend_valid_q;

endmodule

// File: tb/tb_serializer_buffered.sv
// Directed bench for serializer_buffered: a 16-bit and an 8-bit instance driven
// by one linear sequence of steps with hand-computed expected bit streams.
module tb_serializer_buffered;

   logic        clk = 1'b0;
   logic        srst = 1'b0;

   logic [15:0] data16 = '0;
   logic [3:0]  mod16 = '0;
   logic        lsb16 = 1'b0;
   logic        val16 = 1'b0;
   logic        ready16, ser16, sval16, busy16;

   logic [7:0]  data8 = '0;
   logic [2:0]  mod8 = '0;
   logic        lsb8 = 1'b0;
   logic        val8 = 1'b0;
   logic        ready8, ser8, sval8, busy8;

   int n_cmp = 0;
   int n_err = 0;

   logic [7:0] words [10];

   always #5 clk = ~clk;

   serializer_buffered #(.DATA_W(16)) u16 (
      .clk_i          (clk),
      .srst_i         (srst),
      .data_i         (data16),
      .data_mod_i     (mod16),
      .lsb_first_i    (lsb16),
      .data_val_i     (val16),
      .ready_o        (ready16),
      .ser_data_o     (ser16),
      .ser_data_val_o (sval16),
      .busy_o         (busy16)
   );

   serializer_buffered #(.DATA_W(8)) u8 (
      .clk_i          (clk),
      .srst_i         (srst),
      .data_i         (data8),
      .data_mod_i     (mod8),
      .lsb_first_i    (lsb8),
      .data_val_i     (val8),
      .ready_o        (ready8),
      .ser_data_o     (ser8),
      .ser_data_val_o (sval8),
      .busy_o         (busy8)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic check_idle16(input string tag);
      check({tag, ".val"},   32'(sval16),  32'd0);
      check({tag, ".ser"},   32'(ser16),   32'd0);
      check({tag, ".busy"},  32'(busy16),  32'd0);
      check({tag, ".ready"}, 32'(ready16), 32'd1);
   endtask

   task automatic check_bit16(input string tag, input logic exp_bit);
      check({tag, ".val"}, 32'(sval16), 32'd1);
      check({tag, ".bit"}, 32'(ser16),  32'(exp_bit));
   endtask

   task automatic check_bit8(input string tag, input logic exp_bit);
      check({tag, ".val"}, 32'(sval8), 32'd1);
      check({tag, ".bit"}, 32'(ser8),  32'(exp_bit));
   endtask

   function automatic logic stream_bit(input int b);
      int  k = b / 8;
      int  i = b % 8;
      logic [7:0] w = words[k];
      return (k % 2 == 1) ? w[i] : w[7-i];
   endfunction

   initial begin
      logic [15:0] pat;
      logic [15:0] w16;
      int          seen;
      int          k;
      logic        acc;

      words[0] = 8'h3C; words[1] = 8'hA1; words[2] = 8'h7E; words[3] = 8'h05;
      words[4] = 8'hF0; words[5] = 8'h99; words[6] = 8'h12; words[7] = 8'hC8;
      words[8] = 8'h6B; words[9] = 8'hD4;

      // 1. reset held with data_val asserted
      srst = 1'b1; val16 = 1'b1; data16 = 16'hFFFF; val8 = 1'b1; data8 = 8'hFF;
      for (int c = 0; c < 3; c++) begin
         tick();
         check_idle16("rst16");
         check("rst8.val", 32'(sval8), 32'd0);
         check("rst8.ready", 32'(ready8), 32'd1);
      end
      srst = 1'b0; val16 = 1'b0; val8 = 1'b0;
      tick();
      check_idle16("post_rst");

      // 2. 16-bit word, full length, MSB first
      pat = 16'b1010_0101_1100_0011;
      data16 = 16'hA5C3; mod16 = 4'd0; lsb16 = 1'b0; val16 = 1'b1;
      check("t2.ready_pre", 32'(ready16), 32'd1);
      check("t2.val_pre", 32'(sval16), 32'd0);
      tick();
      val16 = 1'b0;
      check("t2.busy", 32'(busy16), 32'd1);
      for (int i = 0; i < 16; i++) begin
         check_bit16($sformatf("t2.b%0d", i), pat[15-i]);
         tick();
      end
      check("t2.end_val", 32'(sval16), 32'd0);
      check("t2.end_ser", 32'(ser16), 32'd0);
      tick();
      check_idle16("t2.idle");

      // 3. 5-bit LSB-first word, then two dropped short words
      pat = 16'b0000_0000_0001_0101;
      data16 = 16'h00F5; mod16 = 4'd5; lsb16 = 1'b1; val16 = 1'b1;
      tick();
      val16 = 1'b0;
      for (int i = 0; i < 5; i++) begin
         check_bit16($sformatf("t3.b%0d", i), pat[i]);
         tick();
      end
      check("t3.end_val", 32'(sval16), 32'd0);
      tick();
      check_idle16("t3.idle");
      mod16 = 4'd2; val16 = 1'b1;
      tick();
      val16 = 1'b0;
      check_idle16("t3.mod2");
      tick();
      check_idle16("t3.mod2b");
      mod16 = 4'd1; val16 = 1'b1;
      tick();
      val16 = 1'b0;
      check_idle16("t3.mod1");
      tick();
      check_idle16("t3.mod1b");

      // 4. A (1011) then B (010) back to back; third offer while pending is ignored
      pat = 16'b0000_0000_0101_1010;
      data16 = 16'hB000; mod16 = 4'd4; lsb16 = 1'b0; val16 = 1'b1;
      tick();
      check_bit16("t4.a0", 1'b1);
      check("t4.ready_a0", 32'(ready16), 32'd1);
      data16 = 16'h4000; mod16 = 4'd3;
      tick();
      check_bit16("t4.a1", 1'b0);
      check("t4.ready_a1", 32'(ready16), 32'd0);
      data16 = 16'hFFFF; mod16 = 4'd0;
      tick();
      check_bit16("t4.a2", 1'b1);
      check("t4.ready_a2", 32'(ready16), 32'd0);
      tick();
      check_bit16("t4.a3", 1'b1);
      check("t4.ready_a3", 32'(ready16), 32'd0);
      tick();
      val16 = 1'b0;
      check_bit16("t4.b0", 1'b0);
      check("t4.ready_b0", 32'(ready16), 32'd1);
      tick();
      check_bit16("t4.b1", 1'b1);
      tick();
      check_bit16("t4.b2", 1'b0);
      tick();
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         if (sval16) seen++;
         tick();
      end
      check("t4.third_ignored", 32'(seen), 32'd0);
      check_idle16("t4.idle");

      // 5. reset mid-word with a word pending
      data16 = 16'hFFFF; mod16 = 4'd0; lsb16 = 1'b0; val16 = 1'b1;
      tick();
      check_bit16("t5.b0", 1'b1);
      data16 = 16'hAAAA;
      tick();
      val16 = 1'b0;
      check("t5.ready_pend", 32'(ready16), 32'd0);
      check("t5.busy_pend", 32'(busy16), 32'd1);
      for (int c = 0; c < 5; c++) tick();
      check_bit16("t5.b6", 1'b1);
      srst = 1'b1;
      tick();
      srst = 1'b0;
      check_idle16("t5.abort");
      seen = 0;
      for (int c = 0; c < 20; c++) begin
         tick();
         if (sval16) seen++;
      end
      check("t5.pend_dropped", 32'(seen), 32'd0);

      // 6a. 8-bit instance: accept on the last bit with pending empty
      data8 = 8'hC5; mod8 = 3'd3; lsb8 = 1'b0; val8 = 1'b1;
      tick();
      val8 = 1'b0;
      check_bit8("t6a.x0", 1'b1);
      tick();
      check_bit8("t6a.x1", 1'b1);
      tick();
      check_bit8("t6a.x2", 1'b0);
      data8 = 8'h5A; mod8 = 3'd3; lsb8 = 1'b1; val8 = 1'b1;
      check("t6a.ready_last", 32'(ready8), 32'd1);
      tick();
      val8 = 1'b0;
      check_bit8("t6a.y0", 1'b0);
      check("t6a.ready_y0", 32'(ready8), 32'd1);
      tick();
      check_bit8("t6a.y1", 1'b1);
      tick();
      check_bit8("t6a.y2", 1'b0);
      tick();
      check("t6a.end_val", 32'(sval8), 32'd0);
      tick();

      // 6b. 10 full-length words streamed with no idle cycle between them
      k = 0;
      data8 = words[0]; mod8 = 3'd0; lsb8 = 1'b0; val8 = 1'b1;
      tick();
      k = 1;
      data8 = words[1]; lsb8 = 1'b1;
      for (int b = 0; b < 80; b++) begin
         check_bit8($sformatf("t6b.b%0d", b), stream_bit(b));
         acc = ready8 && val8;
         tick();
         if (acc) begin
            k++;
            if (k < 10) begin
               data8 = words[k];
               lsb8 = (k % 2 == 1);
            end else begin
               val8 = 1'b0;
            end
         end
      end
      check("t6b.end_val", 32'(sval8), 32'd0);
      check("t6b.all_taken", 32'(k), 32'd10);
      w16 = 16'h0;
      tick();
      check("t6b.busy_end", 32'(busy8), 32'(w16[0]));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
